// File: rtl/bus_grant_mux.sv
// bus_grant_mux: takes the one-hot grant from an 8-way round-robin arbiter,
// latches the winning master and runs its single or burst transfer on the
// shared slave bus. Arbiter lock is held for the whole transfer. A transfer
// ends on its final ack, on a slave timeout (error to the master) or when the
// master withdraws m_cyc (silent abort).
module bus_grant_mux #(
    parameter int AWID    = 32,
    parameter int DWID    = 64,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           m_cyc,
    input  logic [7:0]           m_we,
    input  logic [8*4-1:0]       m_blen,
    input  logic [8*AWID-1:0]    m_adr,
    input  logic [8*DWID-1:0]    m_dat_o,
    output logic [7:0]           m_ack,
    output logic [7:0]           m_err,
    output logic [DWID-1:0]      m_dat_i,
    output logic [7:0]           arb_req,
    output logic [7:0]           arb_lock,
    input  logic [7:0]           arb_sel,
    output logic                 s_cyc,
    output logic                 s_stb,
    output logic                 s_we,
    output logic [AWID-1:0]      s_adr,
    output logic [DWID-1:0]      s_dat_o,
    input  logic                 s_ack,
    input  logic [DWID-1:0]      s_dat_i
);

    // The wait counter only ever holds 0..TIMEOUT-1.
    localparam int              TW     = $clog2(TIMEOUT);
    localparam logic [AWID-1:0] STRIDE = AWID'(DWID / 8);

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        RELEASE
    } state_t;

    state_t          state_q;
    logic [7:0]      owner_q;
    logic [2:0]      idx_q;
    logic [3:0]      beats_q;
    logic [AWID-1:0] adr_q;
    logic            we_q;
    logic [TW-1:0]   tmo_q;

    logic [7:0]      grant;
    logic [7:0]      win_oh;
    logic [2:0]      win_idx;
    logic            in_xfer;
    logic            stb;
    logic            beat_ack;
    logic            tmo_hit;

    // Grant qualification: only requesting masters count, lowest bit wins.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch is inferred.
        grant   = arb_sel & m_cyc;
        win_oh  = grant & (~grant + 8'd1);
        win_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (grant[i]) begin
                win_idx = 3'(i);
            end
        end
    end

    // Beat-level decode of the active transfer.
    always_comb begin
        in_xfer  = (state_q == XFER);
        stb      = in_xfer & m_cyc[idx_q];
        beat_ack = stb & s_ack;
        tmo_hit  = stb & ~s_ack & (tmo_q == TW'(TIMEOUT - 1));
    end

    // Bus and arbiter outputs; acks and errors reach the master in the same cycle.
    always_comb begin
        arb_req  = m_cyc;
        arb_lock = 8'h00;
        if (state_q == IDLE) begin
            arb_lock = grant;
        end else if (in_xfer) begin
            arb_lock = owner_q;
        end
        s_cyc   = stb;
        s_stb   = stb;
        s_we    = in_xfer & we_q;
        s_adr   = in_xfer ? adr_q : '0;
        s_dat_o = in_xfer ? m_dat_o[idx_q*DWID +: DWID] : '0;
        m_dat_i = in_xfer ? s_dat_i : '0;
        m_ack   = beat_ack ? owner_q : 8'h00;
        m_err   = tmo_hit ? owner_q : 8'h00;
    end

    // Transfer FSM: latch on grant, count beats/wait cycles, one release cycle.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the values from before this edge.
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 8'h00;
            idx_q   <= 3'd0;
            beats_q <= 4'd0;
            adr_q   <= '0;
            we_q    <= 1'b0;
            tmo_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant != 8'h00) begin
                        owner_q <= win_oh;
                        idx_q   <= win_idx;
                        beats_q <= m_blen[win_idx*4 +: 4];
                        adr_q   <= m_adr[win_idx*AWID +: AWID];
                        we_q    <= m_we[win_idx];
                        tmo_q   <= '0;
                        state_q <= XFER;
                    end
                end
                XFER: begin
                    if (!stb) begin
                        state_q <= RELEASE;
                    end else if (s_ack) begin
                        tmo_q <= '0;
                        if (beats_q == 4'd0) begin
                            state_q <= RELEASE;
                        end else begin
                            beats_q <= beats_q - 4'd1;
                            adr_q   <= adr_q + STRIDE;
                        end
                    end else if (tmo_hit) begin
                        state_q <= RELEASE;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                RELEASE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_grant_mux.sv
// Bench for bus_grant_mux: directed scenarios with literal expectations, then
// randomized masters, slave, round-robin arbiter and reset pulses. A
// transaction-level model predicts every output each cycle.
module tb_bus_grant_mux;

    localparam int AWID    = 32;
    localparam int DWID    = 64;
    localparam int TIMEOUT = 8;
    localparam int STRIDE  = DWID / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic [7:0]           m_cyc, m_we;
    logic [8*4-1:0]       m_blen;
    logic [8*AWID-1:0]    m_adr;
    logic [8*DWID-1:0]    m_dat_o;
    logic [7:0]           m_ack, m_err;
    logic [DWID-1:0]      m_dat_i;
    logic [7:0]           arb_req, arb_lock, arb_sel;
    logic                 s_cyc, s_stb, s_we;
    logic [AWID-1:0]      s_adr;
    logic [DWID-1:0]      s_dat_o;
    logic                 s_ack;
    logic [DWID-1:0]      s_dat_i;

    bus_grant_mux #(.AWID(AWID), .DWID(DWID), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .m_cyc(m_cyc), .m_we(m_we), .m_blen(m_blen), .m_adr(m_adr), .m_dat_o(m_dat_o),
        .m_ack(m_ack), .m_err(m_err), .m_dat_i(m_dat_i),
        .arb_req(arb_req), .arb_lock(arb_lock), .arb_sel(arb_sel),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_o(s_dat_o),
        .s_ack(s_ack), .s_dat_i(s_dat_i)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: who owns the bus, how many beats done, how long waiting.
    int              cur = -1;       // owning master, -1 when none
    bit              gap = 1'b0;     // the one dead cycle after a transfer
    logic [AWID-1:0] base;
    int              nb, done, waitc;
    bit              mwe;

    logic [7:0]      e_lock, e_ack, e_err;
    bit              e_cyc, e_we;
    logic [AWID-1:0] e_adr;
    logic [DWID-1:0] e_dwr, e_drd;
    int              e_win;

    // Environment: arbiter, masters, slave.
    bit auto_arb = 0, auto_m = 0, auto_s = 0, start_en = 0, abort_en = 0, rst_en = 0, chaos = 0;
    logic [7:0]      arb_q = 8'h00;
    int              last = 7;
    bit              act [8];
    int              got [8];
    logic [3:0]      mbl [8];
    logic [AWID-1:0] madr [8];
    bit              mwa [8];
    int              stall = 0;
    bit              n_ack;
    logic [DWID-1:0] n_dat;

    task automatic compute_expect();
        e_lock = 8'h00; e_ack = 8'h00; e_err = 8'h00; e_cyc = 1'b0; e_we = 1'b0;
        e_adr = '0; e_dwr = '0; e_drd = '0; e_win = -1;
        if (cur < 0 && !gap) begin
            e_lock = arb_sel & m_cyc;
            for (int i = 0; i < 8; i++) if (e_lock[i] && e_win < 0) e_win = i;
        end else if (cur >= 0) begin
            e_lock = 8'(1 << cur);
            e_cyc  = m_cyc[cur];
            if (e_cyc) begin
                e_we  = mwe;
                e_adr = base + AWID'(done * STRIDE);
                e_dwr = m_dat_o[cur*DWID +: DWID];
                if (s_ack) begin
                    e_ack = e_lock;
                    e_drd = s_dat_i;
                end else if (waitc == TIMEOUT - 1) begin
                    e_err = e_lock;
                end
            end
        end
    endtask

    task automatic update_model();
        if (rst) begin
            cur = -1; gap = 1'b0;
        end else if (gap) begin
            gap = 1'b0;
        end else if (cur < 0) begin
            if (e_win >= 0) begin
                cur   = e_win;
                base  = m_adr[e_win*AWID +: AWID];
                nb    = int'(m_blen[e_win*4 +: 4]) + 1;
                mwe   = m_we[e_win];
                done  = 0;
                waitc = 0;
            end
        end else if (!e_cyc) begin
            cur = -1; gap = 1'b1;
        end else if (s_ack) begin
            done++;
            waitc = 0;
            if (done == nb) begin cur = -1; gap = 1'b1; end
        end else if (e_err != 8'h00) begin
            cur = -1; gap = 1'b1;
        end else begin
            waitc++;
        end
    endtask

    task automatic start_master(input int i, input bit we, input int blen, input logic [AWID-1:0] adr);
        act[i] = 1'b1; got[i] = 0; mwa[i] = we; mbl[i] = 4'(blen); madr[i] = adr;
        m_cyc[i] = 1'b1; m_we[i] = we; m_blen[i*4 +: 4] = 4'(blen); m_adr[i*AWID +: AWID] = adr;
    endtask

    task automatic set_m(input int i, input bit cyc, input bit we, input int blen, input logic [AWID-1:0] adr);
        m_cyc[i] = cyc; m_we[i] = we; m_blen[i*4 +: 4] = 4'(blen); m_adr[i*AWID +: AWID] = adr;
    endtask

    // Compare every output against the model half a cycle before the edge.
    task automatic settle_check();
        @(negedge clk);
        compute_expect();
        if (!rst) begin
            check("arb_req", arb_req, m_cyc);
            check("arb_lock", arb_lock, e_lock);
            check("s_cyc", s_cyc, e_cyc);
            check("s_stb", s_stb, e_cyc);
            check("m_ack", m_ack, e_ack);
            check("m_err", m_err, e_err);
            if (e_cyc) begin
                check("s_we", s_we, e_we);
                check("s_adr", s_adr, e_adr);
                check("s_dat_o", s_dat_o, e_dwr);
            end
            if (e_ack != 8'h00) check("m_dat_i", m_dat_i, e_drd);
        end
    endtask

    // Commit this cycle to the model and environment, then drive next inputs.
    task automatic advance();
        logic [7:0] nq;
        int nl, j;
        update_model();
        if (rst) begin
            arb_q = 8'h00; last = 7; stall = 0;
            for (int i = 0; i < 8; i++) act[i] = 1'b0;
        end else begin
            if (auto_arb && (e_lock & arb_q) == 8'h00) begin
                nq = 8'h00; nl = last;
                for (int k = 1; k <= 8; k++) begin
                    j = (last + k) % 8;
                    if (nq == 8'h00 && m_cyc[j]) begin nq = 8'(1 << j); nl = j; end
                end
                arb_q = nq; last = nl;
            end
            if (auto_m) begin
                for (int i = 0; i < 8; i++) begin
                    if (act[i]) begin
                        if (e_ack[i]) begin
                            got[i]++;
                            if (got[i] == int'(mbl[i]) + 1) act[i] = 1'b0;
                        end
                        if (e_err[i]) act[i] = 1'b0;
                        if (act[i] && abort_en && $urandom_range(0, 63) == 0) act[i] = 1'b0;
                    end else if (start_en && $urandom_range(0, 5) == 0) begin
                        act[i] = 1'b1; got[i] = 0; mwa[i] = 1'($urandom_range(0, 1));
                        mbl[i] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                        madr[i] = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFC0 | 32'($urandom_range(0, 63)))
                                                              : 32'($urandom);
                    end
                end
            end
        end
        if (auto_s) begin
            if (stall > 0) begin
                stall--; n_ack = 1'b0;
            end else if ($urandom_range(0, 29) == 0) begin
                stall = $urandom_range(4, 12); n_ack = 1'b0;
            end else begin
                n_ack = ($urandom_range(0, 2) != 0);
            end
            n_dat = {$urandom, $urandom};
        end
        @(posedge clk);
        #1;
        if (rst_en) rst = ($urandom_range(0, 499) == 0);
        if (auto_arb) arb_sel = chaos ? 8'($urandom) : arb_q;
        if (auto_m) begin
            for (int i = 0; i < 8; i++) begin
                m_cyc[i] = act[i]; m_we[i] = mwa[i];
                m_blen[i*4 +: 4] = mbl[i]; m_adr[i*AWID +: AWID] = madr[i];
            end
        end
        if (auto_s) begin s_ack = n_ack; s_dat_i = n_dat; end
        for (int i = 0; i < 8; i++) m_dat_o[i*DWID +: DWID] = {$urandom, $urandom};
    endtask

    task automatic cyc();
        settle_check();
        advance();
    endtask

    initial begin
        int first1, final1, first6, acks1, t;
        logic [7:0] lock6;

        rst = 1'b1; m_cyc = 8'h00; m_we = 8'h00; m_blen = '0; m_adr = '0; m_dat_o = '0;
        arb_sel = 8'h00; s_ack = 1'b0; s_dat_i = '0;
        for (int i = 0; i < 8; i++) begin act[i] = 1'b0; got[i] = 0; mbl[i] = 4'd0; madr[i] = '0; mwa[i] = 1'b0; end
        cyc(); cyc();
        rst = 1'b0;

        // Reset state.
        settle_check();
        check("rst_s_cyc", s_cyc, 1'b0);
        check("rst_lock", arb_lock, 8'h00);
        check("rst_ack", m_ack, 8'h00);
        check("rst_err", m_err, 8'h00);
        advance();

        // Single read, master 3.
        set_m(3, 1'b1, 1'b0, 0, 32'h100);
        cyc();
        arb_sel = 8'h08;
        settle_check(); check("rd_lock_idle", arb_lock, 8'h08); advance();
        settle_check();
        check("rd_s_cyc", s_cyc, 1'b1); check("rd_adr", s_adr, 32'h100);
        check("rd_we", s_we, 1'b0); check("rd_lock", arb_lock, 8'h08);
        advance();
        settle_check(); check("rd_wait_ack", m_ack, 8'h00); advance();
        s_ack = 1'b1; s_dat_i = 64'hDEAD;
        settle_check(); check("rd_ack", m_ack, 8'h08); check("rd_data", m_dat_i, 64'hDEAD); advance();
        s_ack = 1'b0; m_cyc[3] = 1'b0;
        settle_check(); check("rd_rel_cyc", s_cyc, 1'b0); check("rd_rel_lock", arb_lock, 8'h00); advance();
        settle_check(); check("rd_idle_lock", arb_lock, 8'h00); advance();
        arb_sel = 8'h00;

        // Burst write, master 0, four beats.
        set_m(0, 1'b1, 1'b1, 3, 32'h1000); arb_sel = 8'h01;
        cyc();
        arb_sel = 8'h00; s_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            settle_check();
            check("bw_adr", s_adr, 32'h1000 + 32'(8 * k));
            check("bw_ack", m_ack, 8'h01);
            check("bw_we", s_we, 1'b1);
            advance();
        end
        m_cyc[0] = 1'b0;
        settle_check(); check("bw_end_cyc", s_cyc, 1'b0); check("bw_end_ack", m_ack, 8'h00); advance();
        s_ack = 1'b0;
        cyc();

        // Non-one-hot grant: lowest requesting bit wins.
        set_m(3, 1'b1, 1'b0, 0, 32'h300); set_m(5, 1'b1, 1'b0, 0, 32'h500); arb_sel = 8'h28;
        settle_check(); check("nh_lock_idle", arb_lock, 8'h28); advance();
        arb_sel = 8'h00; s_ack = 1'b1;
        settle_check(); check("nh_lock", arb_lock, 8'h08); check("nh_adr", s_adr, 32'h300); advance();
        m_cyc[3] = 1'b0; s_ack = 1'b0;
        cyc();
        arb_sel = 8'h20;
        cyc();
        arb_sel = 8'h00; s_ack = 1'b1;
        settle_check(); check("nh_adr5", s_adr, 32'h500); advance();
        m_cyc[5] = 1'b0; s_ack = 1'b0;
        cyc(); cyc();

        // Contention: masters 1 and 6 through the round-robin arbiter.
        auto_arb = 1; auto_m = 1; arb_q = 8'h00; last = 0; s_ack = 1'b1;
        start_master(1, 1'b0, 1, 32'h1100);
        start_master(6, 1'b1, 1, 32'h6600);
        first1 = -1; final1 = -1; first6 = -1; acks1 = 0; lock6 = 8'h00; t = 0;
        while (t < 40) begin
            settle_check();
            if (s_cyc && first1 < 0) first1 = t;
            if (m_ack == 8'h02) begin acks1++; if (acks1 == 2) final1 = t; end
            if (s_cyc && final1 >= 0 && t > final1 && first6 < 0) begin first6 = t; lock6 = arb_lock; end
            advance();
            t++;
        end
        check("ct_latency", first1, 2);
        check("ct_acks1", acks1, 2);
        check("ct_m6_start", first6, final1 + 3);
        check("ct_m6_lock", lock6, 8'h40);
        auto_arb = 0; auto_m = 0; arb_sel = 8'h00; m_cyc = 8'h00; s_ack = 1'b0;
        cyc();

        // Timeout, master 2.
        set_m(2, 1'b1, 1'b0, 0, 32'h2000); arb_sel = 8'h04;
        cyc();
        arb_sel = 8'h00;
        for (int k = 0; k < 8; k++) begin
            settle_check();
            check("to_err", m_err, (k == 7) ? 8'h04 : 8'h00);
            check("to_ack", m_ack, 8'h00);
            advance();
        end
        m_cyc[2] = 1'b0;
        settle_check(); check("to_rel_cyc", s_cyc, 1'b0); check("to_rel_err", m_err, 8'h00); advance();
        cyc();

        // Abort: master 5 drops after two beats of an eight-beat burst.
        set_m(5, 1'b1, 1'b0, 7, 32'h5000); arb_sel = 8'h20;
        cyc();
        arb_sel = 8'h00; s_ack = 1'b1;
        settle_check(); check("ab_ack0", m_ack, 8'h20); advance();
        settle_check(); check("ab_ack1", m_ack, 8'h20); check("ab_adr1", s_adr, 32'h5008); advance();
        m_cyc[5] = 1'b0;
        settle_check(); check("ab_stb", s_stb, 1'b0); check("ab_noack", m_ack, 8'h00); advance();
        s_ack = 1'b0;
        settle_check(); check("ab_rel_lock", arb_lock, 8'h00); advance();
        set_m(0, 1'b1, 1'b0, 0, 32'h40); arb_sel = 8'h01;
        settle_check(); check("ab_idle_lock", arb_lock, 8'h01); advance();
        arb_sel = 8'h00; s_ack = 1'b1;
        settle_check(); check("ab_next_adr", s_adr, 32'h40); advance();
        m_cyc[0] = 1'b0; s_ack = 1'b0;
        cyc(); cyc();

        // Reset during beat 2 of a burst, then a fresh transfer.
        set_m(4, 1'b1, 1'b1, 5, 32'h4000); arb_sel = 8'h10;
        cyc();
        s_ack = 1'b1;
        cyc(); cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0; arb_sel = 8'h00; s_ack = 1'b0;
        settle_check();
        check("rm_cyc", s_cyc, 1'b0); check("rm_lock", arb_lock, 8'h00); check("rm_ack", m_ack, 8'h00);
        advance();
        arb_sel = 8'h10;
        settle_check(); check("rm_idle_lock", arb_lock, 8'h10); advance();
        arb_sel = 8'h00; s_ack = 1'b1;
        for (int k = 0; k < 6; k++) begin
            settle_check();
            check("rm_ack_beat", m_ack, 8'h10);
            check("rm_adr", s_adr, 32'h4000 + 32'(8 * k));
            advance();
        end
        m_cyc[4] = 1'b0; s_ack = 1'b0;
        settle_check(); check("rm_end_cyc", s_cyc, 1'b0); advance();
        cyc();

        // Randomized traffic with arbiter model, then with an arbitrary arb_sel.
        arb_q = 8'h00; last = 7;
        auto_arb = 1; auto_m = 1; auto_s = 1; start_en = 1; abort_en = 1; rst_en = 1;
        repeat (3000) cyc();
        chaos = 1;
        repeat (1500) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_grant_mux.md
Name: bus_grant_mux

Overview:
- Downstream consumer of the 8-way round-robin arbiter's one-hot grant.
- Drives the arbiter's req/lock inputs from eight bus masters.
- Latches the granted master and runs its single or burst transfer on the shared slave bus, routing ack/data/error back.
- Holds arbiter lock for the whole transfer; aborts on master drop or slave timeout.

Parameters:
AWID, 32, address width
DWID, 64, data width (byte stride per beat = DWID/8)
TIMEOUT, 255, cycles without s_ack before a beat is errored (>=2)

Ports:
clk  input  1  clock
rst  input  1  reset (synchronous, active-high)
m_cyc  input  8  per-master request, level, held until final ack/err
m_we  input  8  per-master write enable
m_blen  input  8*4  per-master beats-1 (0..15), sampled at grant
m_adr  input  8*AWID  per-master start address, sampled at grant
m_dat_o  input  8*DWID  per-master write data, current beat
m_ack  output  8  per-master beat acknowledge
m_err  output  8  per-master timeout error
m_dat_i  output  DWID  read data, broadcast to all masters
arb_req  output  8  to arbiter req
arb_lock  output  8  to arbiter lock
arb_sel  input  8  one-hot grant from arbiter (registered there)
s_cyc  output  1  slave bus cycle
s_stb  output  1  slave bus strobe
s_we  output  1  slave write enable
s_adr  output  AWID  slave address
s_dat_o  output  DWID  slave write data
s_ack  input  1  slave beat acknowledge
s_dat_i  input  DWID  slave read data

Behaviour:
- Clock is clk. Reset is synchronous, active-high on rst; it is the only reset.
- Reset, also when applied mid-transfer:
  - state=IDLE; owner=0, beats=0, tmo=0.
  - All outputs 0: s_cyc, s_stb, m_ack, m_err, arb_lock.
  - No ack/err is issued for an aborted transfer.
- arb_req = m_cyc, always (combinational).
- States: IDLE, XFER, RELEASE.
- IDLE:
  - g = arb_sel & m_cyc.
  - arb_lock = g (combinational), so the arbiter holds its grant across the latch edge.
  - If g != 0, at the clock edge: owner <= g; idx <= encode(g); beats <= m_blen[idx]; adr <= m_adr[idx]; we <= m_we[idx]; tmo <= 0; go to XFER.
  - If arb_sel is non-zero but not one-hot, the lowest set bit of g wins.
- XFER:
  - arb_lock = owner.
  - s_cyc = s_stb = m_cyc[idx]; s_we = we; s_adr = adr; s_dat_o = m_dat_o[idx]; m_dat_i = s_dat_i.
  - m_ack = owner when s_ack & s_stb, else 0 (same cycle, combinational).
  - On s_ack with beats != 0: beats--, adr += DWID/8 (wraps modulo 2^AWID), tmo <= 0.
  - On s_ack with beats == 0: go to RELEASE.
  - No ack: tmo++. When tmo == TIMEOUT-1, m_err = owner for that cycle only (no m_ack), then go to RELEASE.
  - m_cyc[idx] low in XFER: s_stb/s_cyc drop the same cycle, no ack/err; go to RELEASE.
  - s_ack in the same cycle as timeout: the ack wins; tmo is cleared.
  - s_ack while s_stb is low is ignored.
- RELEASE:
  - One cycle with s_cyc=0 and arb_lock=0, so the arbiter rotates. Then go to IDLE.
  - The minimum gap between transfers is 2 cycles.
- Latency: arb_sel showing a requesting master in IDLE gives s_cyc=1 on the next cycle. From m_cyc rising, s_cyc rises 2 cycles later (includes the arbiter's register stage).
- arb_sel is ignored outside IDLE.
- Registers update every cycle; there is no clock enable.

Test Plan:
- Single read: master 3 raises m_cyc with blen=0, adr=0x100; arb_sel=0x08 one cycle later. Required: s_cyc next cycle with s_adr=0x100, s_we=0. Slave acks after 2 cycles with s_dat_i=0xDEAD, giving m_ack=0x08 and m_dat_i=0xDEAD in the same cycle. RELEASE then IDLE, arb_lock=0x08 throughout XFER.
- Burst write: master 0, blen=3, adr=0x1000, slave acks every cycle. Required: s_adr = 0x1000, 0x1008, 0x1010, 0x1018; exactly 4 m_ack pulses to bit 0; s_cyc low on the 5th cycle.
- Contention: masters 1 and 6 request together, arbiter grants 1 first. Required: master 6 gets no s_cyc until master 1's final ack plus the RELEASE cycle. Master 6 then transfers with arb_lock=0x40.
- Timeout: master 2, no s_ack, TIMEOUT=8. Required: m_err=0x04 for exactly one cycle, 7 cycles into XFER (when tmo reaches 7), no m_ack, then RELEASE.
- Abort: master 5 drops m_cyc after beat 1 of a blen=7 burst. Required: s_stb low the same cycle, no further ack, IDLE 2 cycles later.
- Reset mid-burst: rst during beat 2. Required: next cycle s_cyc=0, arb_lock=0, m_ack=0, state IDLE; a fresh request then completes normally.
